// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM states and data widths.
package program_loader_pkg;

  localparam int MAX_WORDS_DEFAULT = 256;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    WRITE   = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } state_t;

endpackage

// File: rtl/program_loader.sv
// Receives a length-prefixed byte stream and writes it as 16-bit words into
// instruction memory, then raises ready for the processor.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              in_ready,
  output logic              imem_we,
  output logic [WORD_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              ready,
  output logic              busy,
  output logic              err,
  output state_t            state
);

  // Handshake: a byte moves on a rising edge where in_valid and in_ready are
  // both 1; in_ready depends only on state, never on in_valid.

  localparam logic [WORD_W-1:0] MAX_LEN = WORD_W'(MAX_WORDS);

  logic [WORD_W-1:0] length;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] len_next;
  state_t            nxt;

  assign len_next = {length[15:8], in_byte};

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) nxt = LEN_HI;
      LEN_HI:          if (in_valid) nxt = LEN_LO;
      LEN_LO: begin
        if (in_valid) begin
          if (len_next == '0)          nxt = DONE;
          else if (len_next > MAX_LEN) nxt = ERR;
          else                         nxt = DATA_HI;
        end
      end
      DATA_HI:         if (in_valid) nxt = DATA_LO;
      DATA_LO:         if (in_valid) nxt = WRITE;
      WRITE:           nxt = (imem_addr == length - 16'd1) ? DONE : DATA_HI;
      default:         nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each is a clean flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      length     <= '0;
      word       <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state    <= nxt;
      in_ready <= (nxt == LEN_HI) || (nxt == LEN_LO) ||
                  (nxt == DATA_HI) || (nxt == DATA_LO);
      busy     <= (nxt == LEN_HI) || (nxt == LEN_LO) || (nxt == DATA_HI) ||
                  (nxt == DATA_LO) || (nxt == WRITE);
      imem_we  <= (nxt == WRITE);
      ready    <= (nxt == DONE);
      err      <= (nxt == ERR);

      case (state)
        IDLE, DONE, ERR: if (start) imem_addr <= '0;
        LEN_HI:  if (in_valid) length[15:8] <= in_byte;
        LEN_LO:  if (in_valid) length[7:0] <= in_byte;
        DATA_HI: if (in_valid) word[15:8] <= in_byte;
        DATA_LO: begin
          if (in_valid) begin
            word[7:0]  <= in_byte;
            imem_wdata <= {word[15:8], in_byte};
          end
        end
        WRITE:   imem_addr <= imem_addr + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MAX_WORDS, default 256, SHALL set the instruction-memory depth in 16-bit words and the largest accepted program length.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-004 Port start  input  1  SHALL be a load-request pulse, sampled only in IDLE, DONE and ERR.
REQ-005 Port in_valid  input  1  SHALL flag that in_byte holds a byte.
REQ-006 Port in_byte  input  8  SHALL carry the byte stream: length high, length low, then instruction bytes high-then-low.
REQ-007 Port in_ready  output  1  SHALL indicate the loader accepts in_byte this cycle.
REQ-008 Port imem_we  output  1  SHALL be the instruction-memory write strobe.
REQ-009 Port imem_addr  output  16  SHALL be the instruction-memory word address.
REQ-010 Port imem_wdata  output  16  SHALL be the instruction word to write.
REQ-011 Port ready  output  1  SHALL tell the processor that the program is loaded and execution may run.
REQ-012 Port busy  output  1  SHALL be high in LEN_HI, LEN_LO, DATA_HI, DATA_LO and WRITE.
REQ-013 Port err  output  1  SHALL be high only in ERR.

Function
REQ-014 A byte SHALL transfer only on a cycle with in_valid=1 and in_ready=1; in_ready SHALL be 1 exactly in LEN_HI, LEN_LO, DATA_HI and DATA_LO.
REQ-015 States SHALL be IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE and ERR.
REQ-016 In IDLE, DONE or ERR, start=1 SHALL move to LEN_HI next cycle, clear imem_addr to 0, and drop ready and err.
REQ-017 start while busy=1 SHALL be ignored.
REQ-018 LEN_HI SHALL latch the accepted byte as length[15:8] and go to LEN_LO.
REQ-019 LEN_LO SHALL latch length[7:0], then go to DONE if length=0, to ERR if length>MAX_WORDS, or else to DATA_HI.
REQ-020 DATA_HI SHALL latch word[15:8] and go to DATA_LO; DATA_LO SHALL latch word[7:0] and go to WRITE.
REQ-021 WRITE SHALL last exactly one cycle with imem_we=1, imem_addr set to the current word index and imem_wdata set to the assembled word.
REQ-022 After WRITE, imem_addr SHALL increment by 1; the state SHALL go to DONE if the written index equals length-1, else to DATA_HI.
REQ-023 imem_we SHALL be 0 in every state except WRITE, and imem_wdata SHALL hold its last value outside WRITE.
REQ-024 ready SHALL be 1 in DONE only; it SHALL rise the cycle after the final WRITE cycle and hold until start or reset.
REQ-025 Stalls of any length (in_valid=0) SHALL hold the state and latched data unchanged.
REQ-026 The word counter SHALL be 16 bits; a length equal to MAX_WORDS SHALL load addresses 0 to MAX_WORDS-1 with no wrap.
REQ-027 ERR SHALL perform no memory write and SHALL be left only by start or reset.

Reset
REQ-028 On rst_n=0, the state SHALL go to IDLE immediately, and in_ready, imem_we, ready, busy and err SHALL be 0.
REQ-029 On rst_n=0, imem_addr, imem_wdata and the length and word registers SHALL be 0.
REQ-030 A reset during a load SHALL abort the load with no further write; already-written words are not recovered.

Structure
REQ-031 A shared package SHALL hold the state enumeration, the MAX_WORDS default, and the byte-width (8) and word-width (16) constants.
REQ-032 The block SHALL be one module with no sub-module; the processor's ready input SHALL be driven directly from ready.

Verification
REQ-033 Reset then start, bytes 00 02 12 34 AB CD -> writes (0,1234h) then (1,ABCDh), ready=1 the cycle after the second write.
REQ-034 Stream bytes 00 00 -> no imem_we, state DONE, ready=1 the cycle after the length-low byte.
REQ-035 Stream bytes 01 01 with MAX_WORDS=256 -> err=1, no writes, ready=0; a later start returns to LEN_HI with err=0.
REQ-036 Same stream as REQ-033 with in_valid toggling 1/0 and a start pulse mid-load -> identical writes, start ignored, in_ready=0 during each WRITE.
REQ-037 rst_n=0 after the first write of a 2-word load -> outputs zero at once, no second write, IDLE after release.
REQ-038 In DONE, start followed by 00 01 FF FF -> ready drops next cycle, write (0,FFFFh), then ready=1.
